tmu_texture_upload_ctrl: RTL and testbench

TMU_TEXTURE_UPLOAD_CTRL -- requirements
Module: tmu_texture_upload_ctrl

---
 rtl/tmu_texture_upload_ctrl.sv | 141 ++++++++++++++
 tb/tb_tmu_texture_upload_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmu_texture_upload_ctrl.sv
// Texture upload controller: gates fragments into the TMU, drains it, then streams texels to texture memory.
// Optional sticky protocol-error detection is enabled by defining TMU_UPLOAD_ERR_CHECK_EN.
module tmu_texture_upload_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_INFLIGHT = 32
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  s_data_valid,
  output logic                  s_data_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  frag_s_valid,
  output logic                  frag_s_ready,
  output logic                  frag_m_valid,
  input  logic                  frag_m_ready,
  input  logic                  tmu_out_fire,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] remain_q;
  logic [CNT_W-1:0]      inflight_q;
  logic [CNT_W-1:0]      inflight_d;
  logic                  mem_wr_en_q;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_q;
  logic [DATA_WIDTH-1:0] mem_wr_data_q;

  logic in_idle;
  logic has_room;
  logic frag_fire;
  logic beat;

  // Fragments only pass while idle and the TMU has room
  assign in_idle      = (state_q == IDLE);
  assign has_room     = (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign frag_m_valid = in_idle && frag_s_valid && has_room;
  assign frag_s_ready = in_idle && frag_m_ready && has_room;
  assign frag_fire    = frag_m_valid && frag_m_ready;
  assign beat         = (state_q == LOAD) && s_data_valid;

  assign cmd_ready    = in_idle;
  assign s_data_ready = (state_q == LOAD);
  assign busy         = !in_idle;
  assign done         = (state_q == DONE);
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;

  // Simultaneous entry and exit cancel; an exit at zero is ignored
  always_comb begin
    inflight_d = inflight_q;
    if (frag_fire && !tmu_out_fire) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!frag_fire && tmu_out_fire && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      inflight_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      mem_wr_en_q <= beat;
      if (beat) begin
        mem_wr_addr_q <= addr_q;
        mem_wr_data_q <= s_data;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            remain_q <= cmd_len;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_q == '0) begin
            state_q <= (remain_q == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (s_data_valid) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            remain_q <= remain_q - ADDR_WIDTH'(1);
            if (remain_q == ADDR_WIDTH'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TMU_UPLOAD_ERR_CHECK_EN
  logic err_q;

  // Sticky: TMU exit with nothing inside, or texel data offered while idle
  always_ff @(posedge aclk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((tmu_out_fire && (inflight_q == '0) && !frag_fire) ||
                 (s_data_valid && in_idle)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tmu_texture_upload_ctrl.sv
// Self-checking bench for tmu_texture_upload_ctrl: fragment-gate vector table, directed
// upload sequences, and randomized traffic against a behavioural model.
module tb_tmu_texture_upload_ctrl;

  localparam int unsigned AW   = 17;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXI = 32;
  localparam logic [DW-1:0] DATA_BASE = 32'hA500_0000;
`ifdef TMU_UPLOAD_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          s_data_valid, s_data_ready;
  logic [DW-1:0] s_data;
  logic          frag_s_valid, frag_s_ready, frag_m_valid, frag_m_ready;
  logic          tmu_out_fire;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          busy, done, err;

  tmu_texture_upload_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI)) dut (
    .aclk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data(s_data),
    .frag_s_valid(frag_s_valid), .frag_s_ready(frag_s_ready),
    .frag_m_valid(frag_m_valid), .frag_m_ready(frag_m_ready),
    .tmu_out_fire(tmu_out_fire),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 1000;

  // Per-cycle log of outputs, sampled mid-cycle
  logic          en_l[64], done_l[64], busy_l[64], cmdr_l[64], sdr_l[64], mv_l[64], err_l[64];
  logic [AW-1:0] addr_l[64];
  logic [DW-1:0] data_l[64];
  bit            x_en[64], x_done[64];
  logic [AW-1:0] x_addr[64];
  logic [DW-1:0] x_data[64];

  always @(negedge clk) begin
    if (cyc >= 0 && cyc < 64) begin
      en_l[cyc]   <= mem_wr_en;
      addr_l[cyc] <= mem_wr_addr;
      data_l[cyc] <= mem_wr_data;
      done_l[cyc] <= done;
      busy_l[cyc] <= busy;
      cmdr_l[cyc] <= cmd_ready;
      sdr_l[cyc]  <= s_data_ready;
      mv_l[cyc]   <= frag_m_valid;
      err_l[cyc]  <= err;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] dat(input int c);
    return DATA_BASE + DW'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc    = cyc + 1;
    s_data = dat(cyc);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) begin
      x_en[i] = 1'b0; x_done[i] = 1'b0; x_addr[i] = '0; x_data[i] = '0;
    end
  endtask

  // A beat accepted in cycle c-1 shows on the write port in cycle c
  task automatic exp_wr(input int c, input logic [AW-1:0] a);
    x_en[c]   = 1'b1;
    x_addr[c] = a;
    x_data[c] = dat(c - 1);
  endtask

  task automatic cmp_log(input string tag, input int last);
    for (int c = 0; c <= last; c++) begin
      chk($sformatf("%s_wr_en@%0d", tag, c), 64'(en_l[c]), 64'(x_en[c]));
      if (x_en[c]) begin
        chk($sformatf("%s_wr_addr@%0d", tag, c), 64'(addr_l[c]), 64'(x_addr[c]));
        chk($sformatf("%s_wr_data@%0d", tag, c), 64'(data_l[c]), 64'(x_data[c]));
      end
      chk($sformatf("%s_done@%0d", tag, c), 64'(done_l[c]), 64'(x_done[c]));
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_data_valid = 1'b0; frag_s_valid = 1'b0; frag_m_ready = 1'b0; tmu_out_fire = 1'b0;
    cyc = 1000;
    tick();
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_s_data_ready", 64'(s_data_ready), 64'(0));
    chk("rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
    chk("rst_mem_wr_addr", 64'(mem_wr_addr), 64'(0));
    chk("rst_mem_wr_data", 64'(mem_wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc    = 0;
    s_data = dat(0);
    clear_exp();
  endtask

  typedef struct {
    int rep;
    bit fsv, fmr, fire;
    bit exp_mv, exp_sr;
  } vec_t;

  vec_t tbl[14];

  // Behavioural model state
  int            m_phase;   // 0 idle, 1 waiting for TMU to empty, 2 loading, 3 done pulse
  int            m_infl;
  bit            m_en, m_err;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [AW-1:0] m_addrs[$];

  initial begin
    //              rep fsv fmr fire mv sr
    tbl[0]  = '{1,  0, 0, 0, 0, 0};
    tbl[1]  = '{1,  1, 0, 0, 1, 0};
    tbl[2]  = '{1,  0, 1, 0, 0, 1};
    tbl[3]  = '{32, 1, 1, 0, 1, 1};   // fill to MAX
    tbl[4]  = '{1,  1, 1, 0, 0, 0};   // full
    tbl[5]  = '{1,  1, 1, 1, 0, 0};   // full with exit: gate closed, count drops to MAX-1
    tbl[6]  = '{1,  1, 1, 1, 1, 1};   // entry + exit together: unchanged
    tbl[7]  = '{1,  1, 1, 0, 1, 1};   // back to MAX
    tbl[8]  = '{1,  1, 1, 0, 0, 0};
    tbl[9]  = '{32, 0, 0, 1, 0, 0};   // drain to zero
    tbl[10] = '{1,  0, 0, 1, 0, 0};   // exit at zero stays zero
    tbl[11] = '{32, 1, 1, 0, 1, 1};
    tbl[12] = '{1,  1, 1, 0, 0, 0};
    tbl[13] = '{32, 0, 0, 1, 0, 0};

    // Fragment gate vectors
    reset_dut();
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        frag_s_valid = tbl[r].fsv; frag_m_ready = tbl[r].fmr; tmu_out_fire = tbl[r].fire;
        @(negedge clk);
        chk($sformatf("tbl%0d.%0d_frag_m_valid", r, k), 64'(frag_m_valid), 64'(tbl[r].exp_mv));
        chk($sformatf("tbl%0d.%0d_frag_s_ready", r, k), 64'(frag_s_ready), 64'(tbl[r].exp_sr));
        tick();
      end
    end

    // A: length 4 from 0x100 with continuous data
    reset_dut();
    cmd_valid = 1'b1; cmd_addr = AW'(17'h100); cmd_len = AW'(4); s_data_valid = 1'b1;
    chk("A_cmd_ready_c0", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    run_to(12);
    for (int i = 0; i < 4; i++) exp_wr(3 + i, AW'(17'h100 + i));
    x_done[6] = 1'b1;
    cmp_log("A", 11);
    chk("A_busy_c1", 64'(busy_l[1]), 64'(1));
    chk("A_cmd_ready_c1", 64'(cmdr_l[1]), 64'(0));
    chk("A_s_data_ready_c1", 64'(sdr_l[1]), 64'(0));
    chk("A_s_data_ready_c2", 64'(sdr_l[2]), 64'(1));
    chk("A_cmd_ready_c7", 64'(cmdr_l[7]), 64'(1));
    chk("A_busy_c7", 64'(busy_l[7]), 64'(0));

    // B: three fragments in flight, exits at cycles 5, 9, 12 after acceptance
    reset_dut();
    frag_s_valid = 1'b1; frag_m_ready = 1'b1;
    repeat (3) tick();
    frag_m_ready = 1'b0;
    cyc = 0; s_data = dat(0);
    cmd_valid = 1'b1; cmd_addr = AW'(17'h40); cmd_len = AW'(2); s_data_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    while (cyc <= 24) begin
      tmu_out_fire = (cyc == 5 || cyc == 9 || cyc == 12);
      tick();
    end
    tmu_out_fire = 1'b0;
    exp_wr(15, AW'(17'h40));
    exp_wr(16, AW'(17'h41));
    x_done[16] = 1'b1;
    cmp_log("B", 24);
    chk("B_frag_m_valid_c0", 64'(mv_l[0]), 64'(1));
    for (int c = 1; c <= 16; c++) chk($sformatf("B_frag_m_valid_c%0d", c), 64'(mv_l[c]), 64'(0));
    chk("B_frag_m_valid_c17", 64'(mv_l[17]), 64'(1));

    // C: address wrap
    reset_dut();
    cmd_valid = 1'b1; cmd_addr = AW'(17'h1FFFF); cmd_len = AW'(3); s_data_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    run_to(10);
    exp_wr(3, AW'(17'h1FFFF)); exp_wr(4, AW'(17'h00000)); exp_wr(5, AW'(17'h00001));
    x_done[5] = 1'b1;
    cmp_log("C", 9);

    // D: zero length
    reset_dut();
    cmd_valid = 1'b1; cmd_addr = AW'(17'h55); cmd_len = '0; s_data_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    run_to(9);
    x_done[2] = 1'b1;
    cmp_log("D", 8);
    chk("D_busy_c1", 64'(busy_l[1]), 64'(1));
    chk("D_busy_c2", 64'(busy_l[2]), 64'(1));
    chk("D_s_data_ready_c2", 64'(sdr_l[2]), 64'(0));
    chk("D_cmd_ready_c3", 64'(cmdr_l[3]), 64'(1));

    // E: reset pulsed after the second of six beats
    reset_dut();
    cmd_valid = 1'b1; cmd_addr = AW'(17'h200); cmd_len = AW'(6); s_data_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    run_to(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_to(21);
    exp_wr(3, AW'(17'h200)); exp_wr(4, AW'(17'h201));
    cmp_log("E", 20);
    for (int c = 5; c <= 20; c++) chk($sformatf("E_busy_c%0d", c), 64'(busy_l[c]), 64'(0));
    chk("E_wr_addr_c5", 64'(addr_l[5]), 64'(0));
    chk("E_cmd_ready_c5", 64'(cmdr_l[5]), 64'(1));

    // Error detection: TMU exit at zero, then data offered while idle
    reset_dut();
    tmu_out_fire = 1'b1;
    tick();
    tmu_out_fire = 1'b0;
    run_to(7);
    chk("ERR_fire_c0", 64'(err_l[0]), 64'(0));
    for (int c = 1; c <= 6; c++) chk($sformatf("ERR_fire_c%0d", c), 64'(err_l[c]), 64'(ERR_EN));
    reset_dut();
    s_data_valid = 1'b1;
    tick();
    s_data_valid = 1'b0;
    run_to(5);
    chk("ERR_sdv_c0", 64'(err_l[0]), 64'(0));
    for (int c = 1; c <= 4; c++) chk($sformatf("ERR_sdv_c%0d", c), 64'(err_l[c]), 64'(ERR_EN));

    // Randomized traffic against the behavioural model
    reset_dut();
    m_phase = 0; m_infl = 0; m_en = 1'b0; m_err = 1'b0; m_waddr = '0; m_wdata = '0;
    m_addrs.delete();
    for (int n = 0; n < 2000; n++) begin
      bit inc, room;
      int infl_old;
      cmd_valid    = ($urandom_range(0, 4) == 0);
      cmd_len      = AW'($urandom_range(0, 7));
      cmd_addr     = ($urandom_range(0, 3) == 0) ? AW'(17'h1FFFC + $urandom_range(0, 3)) : AW'($urandom);
      s_data_valid = ($urandom_range(0, 3) != 0);
      s_data       = DW'($urandom);
      frag_s_valid = ($urandom_range(0, 9) < 6);
      frag_m_ready = ($urandom_range(0, 9) < 6);
      tmu_out_fire = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      room = (m_infl < int'(MAXI));
      chk("R_cmd_ready", 64'(cmd_ready), 64'(m_phase == 0));
      chk("R_busy", 64'(busy), 64'(m_phase != 0));
      chk("R_done", 64'(done), 64'(m_phase == 3));
      chk("R_s_data_ready", 64'(s_data_ready), 64'(m_phase == 2));
      chk("R_frag_m_valid", 64'(frag_m_valid), 64'(m_phase == 0 && frag_s_valid && room));
      chk("R_frag_s_ready", 64'(frag_s_ready), 64'(m_phase == 0 && frag_m_ready && room));
      chk("R_mem_wr_en", 64'(mem_wr_en), 64'(m_en));
      if (m_en) begin
        chk("R_mem_wr_addr", 64'(mem_wr_addr), 64'(m_waddr));
        chk("R_mem_wr_data", 64'(mem_wr_data), 64'(m_wdata));
      end
      chk("R_err", 64'(err), 64'(m_err));
      // Advance the model by one clock
      inc      = (m_phase == 0) && frag_s_valid && frag_m_ready && room;
      infl_old = m_infl;
      if (ERR_EN && ((tmu_out_fire && infl_old == 0 && !inc) || (s_data_valid && m_phase == 0)))
        m_err = 1'b1;
      if (inc && !tmu_out_fire) m_infl++;
      else if (!inc && tmu_out_fire && m_infl > 0) m_infl--;
      m_en = 1'b0;
      case (m_phase)
        0: if (cmd_valid) begin
             for (int i = 0; i < int'(cmd_len); i++) m_addrs.push_back(AW'(cmd_addr + i));
             m_phase = 1;
           end
        1: if (infl_old == 0) m_phase = (m_addrs.size() == 0) ? 3 : 2;
        2: if (s_data_valid) begin
             m_en    = 1'b1;
             m_waddr = m_addrs.pop_front();
             m_wdata = s_data;
             if (m_addrs.size() == 0) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
